button_event_queue: RTL and testbench

- Front-end stage that sits directly upstream of the push-button sequence detectors.
- Synchronises and debounces the raw BTNL/BTNR pins, converts each clean press into a single event code, and queues events in a small FIFO.
- Events are presented to the downstream detector over a valid/ready handshake, so no press is lost while the consumer is busy.

---
 rtl/button_event_queue.sv | 145 ++++++++++++++
 tb/tb_button_event_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Button front end: syncs and debounces BTNL/BTNR, turns clean edges into event codes and queues them.
// Define BUTTON_EVENT_QUEUE_RELEASE_EVENTS_EN to queue release events as well as presses.
module button_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 262143,
  parameter int unsigned CNT_W           = 18,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        btnl,
  input  logic                        btnr,
  input  logic                        ev_ready,
  input  logic                        clear_flags,
  output logic                        ev_valid,
  output logic [1:0]                  ev_code,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        p1_level,
  output logic                        p2_level,
  output logic                        overflow,
  output logic                        collide
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] DepthVal = (AW+1)'(FIFO_DEPTH);

  // Index 0 is BTNL (P1), index 1 is BTNR (P2).
  logic [1:0]       raw;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       level_q, level_d, level_prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign raw = {btnr, btnl};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
    end
  end

  assign p1_level = level_q[0];
  assign p2_level = level_q[1];

  logic [1:0] press, edge_any, push_code;
  logic       push, collide_set;

  assign press = level_q & ~level_prev_q;

`ifdef BUTTON_EVENT_QUEUE_RELEASE_EVENTS_EN
  logic [1:0] rel_e;
  assign rel_e     = ~level_q & level_prev_q;
  assign edge_any  = press | rel_e;
  // Only one edge is live when pushing, so any release bit marks the release flag.
  assign push_code = {|rel_e, edge_any[1]};
`else
  assign edge_any  = press;
  assign push_code = {1'b0, edge_any[1]};
`endif

  assign collide_set = &edge_any;
  assign push        = ^edge_any;

  logic [AW:0] wptr_q, rptr_q;
  logic [1:0]  mem_q [FIFO_DEPTH];
  logic        full, empty, pop, push_ok, overflow_set;

  assign ev_count     = wptr_q - rptr_q;
  assign full         = (ev_count == DepthVal);
  assign empty        = (ev_count == '0);
  assign pop          = ~empty & ev_ready;
  // A pop frees the slot this cycle, so a push into a full queue still lands.
  assign push_ok      = push & (~full | pop);
  assign overflow_set = push & full & ~pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= push_code;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign ev_valid = ~empty;
  assign ev_code  = empty ? 2'b00 : mem_q[rptr_q[AW-1:0]];

  logic overflow_q, overflow_d, collide_q, collide_d;

  always_comb begin
    overflow_d = overflow_q;
    collide_d  = collide_q;
    if (clear_flags) begin
      overflow_d = 1'b0;
      collide_d  = 1'b0;
    end
    if (overflow_set) overflow_d = 1'b1;
    if (collide_set)  collide_d  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      collide_q  <= collide_d;
    end
  end

  assign overflow = overflow_q;
  assign collide  = collide_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Randomised bench for button_event_queue against a queue-based behavioural model, plus directed
// scenarios with hand-computed expectations (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_button_event_queue;

  localparam int unsigned DC    = 4;
  localparam int unsigned DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n, btnl, btnr, ev_ready, clear_flags;
  logic       ev_valid, p1_level, p2_level, overflow, collide;
  logic [1:0] ev_code;
  logic [2:0] ev_count;

  button_event_queue #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (18),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .btnl       (btnl),
    .btnr       (btnr),
    .ev_ready   (ev_ready),
    .clear_flags(clear_flags),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_count   (ev_count),
    .p1_level   (p1_level),
    .p2_level   (p2_level),
    .overflow   (overflow),
    .collide    (collide)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: raw samples delayed two edges, a run length of disagreeing samples,
  // and a plain queue of event codes.
  bit         m_s1 [2];
  bit         m_s2 [2];
  bit         m_lvl [2];
  bit         m_prev [2];
  int         m_run [2];
  logic [1:0] mq [$];
  bit         m_ovf, m_col;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0; m_run[i] = 0;
    end
    mq.delete();
    m_ovf = 0;
    m_col = 0;
  endtask

  task automatic model_edge(input bit l, input bit r, input bit rdy, input bit clr);
    bit ev [2];
    bit rl [2];
    bit set_col, set_ovf, pop;
    int sz;
    bit raw [2];
    raw[0] = l;
    raw[1] = r;
    for (int i = 0; i < 2; i++) begin
      rl[i] = !m_lvl[i] && m_prev[i];
`ifdef BUTTON_EVENT_QUEUE_RELEASE_EVENTS_EN
      ev[i] = (m_lvl[i] != m_prev[i]);
`else
      ev[i] = m_lvl[i] && !m_prev[i];
`endif
    end
    sz      = mq.size();
    pop     = (sz > 0) && rdy;
    set_col = ev[0] && ev[1];
    set_ovf = 0;
    if (pop) void'(mq.pop_front());
    if (ev[0] != ev[1]) begin
      if (sz < DEPTH || pop) mq.push_back({rl[ev[1] ? 1 : 0], ev[1]});
      else set_ovf = 1;
    end
    if (set_col) m_col = 1; else if (clr) m_col = 0;
    if (set_ovf) m_ovf = 1; else if (clr) m_ovf = 0;
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = m_lvl[i];
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  task automatic compare_all();
    logic [1:0] exp_code;
    exp_code = (mq.size() > 0) ? mq[0] : 2'b00;
    check("ev_valid", ev_valid, mq.size() > 0);
    check("ev_code",  ev_code,  exp_code);
    check("ev_count", ev_count, mq.size());
    check("p1_level", p1_level, m_lvl[0]);
    check("p2_level", p2_level, m_lvl[1]);
    check("overflow", overflow, m_ovf);
    check("collide",  collide,  m_col);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit l, input bit r, input bit rdy, input bit clr);
    btnl = l; btnr = r; ev_ready = rdy; clear_flags = clr;
    @(posedge clock);
    model_edge(l, r, rdy, clr);
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic press(input int b, input int rdy_at);
    for (int k = 0; k < 14; k++) step(k < 7 && b == 0, k < 7 && b == 1, k == rdy_at, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 14; k++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 0;
    #1;
    check("rst_valid",    ev_valid, 0);
    check("rst_code",     ev_code,  0);
    check("rst_count",    ev_count, 0);
    check("rst_levels",   {p1_level, p2_level}, 0);
    check("rst_flags",    {overflow, collide}, 0);
    model_reset();
    btnl = 0; btnr = 0; ev_ready = 0; clear_flags = 0;
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; btnl = 0; btnr = 0; ev_ready = 0; clear_flags = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_state", {ev_valid, ev_code, ev_count, p1_level, p2_level, overflow, collide}, 0);
    reset_n = 1;
    @(negedge clock);

    // 1: hold btnl, no consumer.
    for (int k = 0; k < 14; k++) begin
      step(k < 7, 0, 0, 0);
      if (k == 4) check("t1_lvl_early", p1_level, 0);
      if (k == 5) check("t1_lvl", p1_level, 1);
      if (k == 5) check("t1_valid_early", ev_valid, 0);
      if (k == 6) check("t1_valid", ev_valid, 1);
      if (k == 6) check("t1_code", ev_code, 2'b00);
      if (k == 12) check("t1_count", ev_count, 1);
    end
    drain();

    // 2: bounce btnr then hold; push must land six edges after the final rise.
    for (int k = 0; k < 4; k++) step(k % 2 == 0, 0 == 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, k % 2 == 0, 0, 0);
      check("t2_no_early", p2_level, 0);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0);
      if (k == 5) check("t2_not_yet", ev_valid, 0);
      if (k == 6) check("t2_code", {ev_valid, ev_code, ev_count}, {1'b1, 2'b01, 3'd1});
    end
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0);
    drain();

    // 3: five presses overflow a depth-4 queue.
    for (int p = 0; p < 5; p++) press(p % 2, -1);
`ifndef BUTTON_EVENT_QUEUE_RELEASE_EVENTS_EN
    check("t3_count", ev_count, 4);
    check("t3_ovf", overflow, 1);
    for (int p = 0; p < 4; p++) begin
      check("t3_order", ev_code, p % 2);
      step(0, 0, 1, 0);
    end
`endif
    step(0, 0, 0, 1);
    check("t3_clear", overflow, 0);
    drain();

    // 4: full queue, push coincides with a pop.
    for (int p = 0; p < 4; p++) press(p % 2, -1);
    press(0, 6);
`ifndef BUTTON_EVENT_QUEUE_RELEASE_EVENTS_EN
    check("t4_count", ev_count, 4);
    check("t4_ovf", overflow, 0);
`endif
    drain();

    // 5: simultaneous rise on both buttons.
    for (int k = 0; k < 7; k++) step(1, 1, 0, 0);
    check("t5_col", collide, 1);
    check("t5_count", ev_count, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0);
    drain();

    // 6: reset with a partly full queue and a debounce in flight.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 7; k++) step(p == 1, p != 1, 0, 0);
      for (int k = 0; k < 7; k++) step(0, 0, 1 == 0, 0);
    end
`ifndef BUTTON_EVENT_QUEUE_RELEASE_EVENTS_EN
    check("t6_count", ev_count, 3);
`endif
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 12; k++) step(0, 0, 0, 0);
    check("t6_no_stale", ev_valid, 0);

    // Random phase: held levels with occasional glitches, sporadic consumer and clears.
    begin
      bit tl, tr;
      tl = 0;
      tr = 0;
      for (int n = 0; n < 3000; n++) begin
        bit l, r;
        if ($urandom_range(11) == 0) tl = ~tl;
        if ($urandom_range(11) == 0) tr = ~tr;
        l = tl ^ ($urandom_range(19) == 0);
        r = tr ^ ($urandom_range(19) == 0);
        step(l, r, $urandom_range(3) == 0, $urandom_range(49) == 0);
        if (n == 1500) do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
